// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar ID order tracker.
// Holds the default configuration and the per-ID table entry layout for that
// configuration. Modules import this package with xbar_pkg::*.
package xbar_pkg;

  localparam int unsigned DEF_SLAVES     = 2;
  localparam int unsigned DEF_MAX_PER_ID = 4;

  // A single-slave build still needs a 1-bit dest field.
  localparam int unsigned DEST_W = (DEF_SLAVES > 1) ? $clog2(DEF_SLAVES) : 1;
  localparam int unsigned CNT_W  = $clog2(DEF_MAX_PER_ID + 1);

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [DEST_W-1:0] dest;
  } id_entry_t;

endpackage

// File: rtl/xbar_id_entry.sv
// One table entry of the ID order tracker: outstanding-burst counter plus the
// destination slave of those bursts.
// Ports:
//   ACLK, ARESETn  clock, synchronous active-low reset
//   inc, dec       issue / retire for this ID (both together leave cnt unchanged)
//   load, dest_in  capture destination of an issued burst
//   cnt, dest      registered entry state
module xbar_id_entry
  import xbar_pkg::*;
#(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned DEST_W  = 1,
  parameter int unsigned MAX_CNT = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              inc,
  input  logic              dec,
  input  logic              load,
  input  logic [DEST_W-1:0] dest_in,
  output logic [CNT_W-1:0]  cnt,
  output logic [DEST_W-1:0] dest
);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt  <= '0;
      dest <= '0;
    end else begin
      if (inc && !dec)
        cnt <= cnt + CNT_W'(1);
      else if (dec && !inc)
        cnt <= cnt - CNT_W'(1);
      if (load)
        dest <= dest_in;
    end
  end

  // The top-level block/retire gating must keep the counter inside 0..MAX_CNT.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      assert (!(inc && !dec && cnt == CNT_W'(MAX_CNT)))
        else $error("xbar_id_entry: counter overflow");
      assert (!(dec && !inc && cnt == '0))
        else $error("xbar_id_entry: counter underflow");
    end
  end

endmodule

// File: rtl/xbar_id_order_tracker.sv
// Per-ID outstanding-transaction tracker for one master-side crossbar port.
// Allows up to MAX_PER_ID outstanding bursts per ID as long as they all target
// the same slave (keeps AXI same-ID ordering), and caps the port total at
// MAX_TOTAL.
// Ports:
//   ACLK, ARESETn            clock, synchronous active-low reset
//   req_id/req_dest/req_valid head-of-FIFO request
//   req_block                combinational: request must not be forwarded
//   req_fire                 request forwarded this cycle
//   rsp_id/rsp_last/rsp_fire response beat accepted into the return FIFO
//   total_cnt, idle          outstanding bursts on this port, total_cnt==0
//   err_underflow            sticky: retire for an ID with zero count
//   err_overissue            sticky: req_fire while req_block
module xbar_id_order_tracker
  import xbar_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned slaves         = DEF_SLAVES,
  parameter int unsigned MAX_PER_ID     = DEF_MAX_PER_ID,
  parameter int unsigned MAX_TOTAL      = 8,
  parameter int unsigned RETIRE_ON_LAST = 1
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic [ID_WIDTH-1:0]              req_id,
  input  logic [((slaves > 1) ? $clog2(slaves) : 1)-1:0] req_dest,
  input  logic                             req_valid,
  output logic                             req_block,
  input  logic                             req_fire,
  input  logic [ID_WIDTH-1:0]              rsp_id,
  input  logic                             rsp_last,
  input  logic                             rsp_fire,
  output logic [$clog2(MAX_TOTAL+1)-1:0]   total_cnt,
  output logic                             idle,
  output logic                             err_underflow,
  output logic                             err_overissue
);

  localparam int unsigned N_IDS = 1 << ID_WIDTH;
  localparam int unsigned ENT_DEST_W = (slaves > 1) ? $clog2(slaves) : 1;
  localparam int unsigned ENT_CNT_W  = $clog2(MAX_PER_ID + 1);
  localparam int unsigned TOT_W      = $clog2(MAX_TOTAL + 1);

  logic [ENT_CNT_W-1:0]  cnt  [N_IDS];
  logic [ENT_DEST_W-1:0] dest [N_IDS];

  logic [ENT_CNT_W-1:0]  head_cnt;
  logic [ENT_DEST_W-1:0] head_dest;
  logic [ENT_CNT_W-1:0]  rsp_cnt;
  logic retire, retire_ok, issue;
  logic hazard, id_full, tot_full;

  always_comb begin
    head_cnt  = cnt[req_id];
    head_dest = dest[req_id];
    rsp_cnt   = cnt[rsp_id];

    retire    = rsp_fire && (rsp_last || (RETIRE_ON_LAST == 0));
    // A retire on an empty ID frees nothing, so it must not open the total cap.
    retire_ok = retire && (rsp_cnt != '0);

    hazard   = (head_cnt != '0) && (head_dest != req_dest);
    id_full  = (head_cnt == ENT_CNT_W'(MAX_PER_ID));
    tot_full = (total_cnt == TOT_W'(MAX_TOTAL));

    req_block = !req_valid || hazard || id_full || (tot_full && !retire_ok);
    issue     = req_fire && !req_block;
  end

  for (genvar i = 0; i < N_IDS; i++) begin : g_entry
    logic hit_req, hit_rsp;
    assign hit_req = issue && (req_id == ID_WIDTH'(i));
    assign hit_rsp = retire_ok && (rsp_id == ID_WIDTH'(i));

    xbar_id_entry #(
      .CNT_W   (ENT_CNT_W),
      .DEST_W  (ENT_DEST_W),
      .MAX_CNT (MAX_PER_ID)
    ) u_entry (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .inc     (hit_req),
      .dec     (hit_rsp),
      .load    (hit_req),
      .dest_in (req_dest),
      .cnt     (cnt[i]),
      .dest    (dest[i])
    );
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      total_cnt     <= '0;
      err_underflow <= 1'b0;
      err_overissue <= 1'b0;
    end else begin
      case ({issue, retire_ok})
        2'b10:   total_cnt <= total_cnt + TOT_W'(1);
        2'b01:   total_cnt <= total_cnt - TOT_W'(1);
        default: total_cnt <= total_cnt;
      endcase
      if (retire && !retire_ok)
        err_underflow <= 1'b1;
      if (req_fire && req_block)
        err_overissue <= 1'b1;
    end
  end

  assign idle = (total_cnt == '0);

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      assert (!(issue && !retire_ok && tot_full))
        else $error("xbar_id_order_tracker: total_cnt overflow");
    end
  end

endmodule

// File: tb/tb_xbar_id_order_tracker.sv
// Directed testbench for xbar_id_order_tracker. Instance dut retires on the
// last beat only; instance dut_b retires on every beat.
module tb_xbar_id_order_tracker;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;

  logic [3:0] req_id = '0;
  logic [0:0] req_dest = '0;
  logic       req_valid = 1'b0, req_fire = 1'b0;
  logic [3:0] rsp_id = '0;
  logic       rsp_last = 1'b0, rsp_fire = 1'b0;
  logic       req_block, idle, err_underflow, err_overissue;
  logic [3:0] total_cnt;

  logic [3:0] b_req_id = '0;
  logic [0:0] b_req_dest = '0;
  logic       b_req_valid = 1'b0, b_req_fire = 1'b0;
  logic [3:0] b_rsp_id = '0;
  logic       b_rsp_last = 1'b0, b_rsp_fire = 1'b0;
  logic       b_req_block, b_idle, b_err_underflow, b_err_overissue;
  logic [3:0] b_total_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  xbar_id_order_tracker #(
    .ID_WIDTH(4), .slaves(2), .MAX_PER_ID(4), .MAX_TOTAL(8), .RETIRE_ON_LAST(1)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_id(req_id), .req_dest(req_dest), .req_valid(req_valid),
    .req_block(req_block), .req_fire(req_fire),
    .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_fire(rsp_fire),
    .total_cnt(total_cnt), .idle(idle),
    .err_underflow(err_underflow), .err_overissue(err_overissue)
  );

  xbar_id_order_tracker #(
    .ID_WIDTH(4), .slaves(2), .MAX_PER_ID(4), .MAX_TOTAL(8), .RETIRE_ON_LAST(0)
  ) dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_id(b_req_id), .req_dest(b_req_dest), .req_valid(b_req_valid),
    .req_block(b_req_block), .req_fire(b_req_fire),
    .rsp_id(b_rsp_id), .rsp_last(b_rsp_last), .rsp_fire(b_rsp_fire),
    .total_cnt(b_total_cnt), .idle(b_idle),
    .err_underflow(b_err_underflow), .err_overissue(b_err_overissue)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic req(input logic [3:0] id, input logic d, input logic v, input logic f);
    req_id = id; req_dest = d; req_valid = v; req_fire = f;
    #1;
  endtask

  task automatic rsp(input logic [3:0] id, input logic l, input logic f);
    rsp_id = id; rsp_last = l; rsp_fire = f;
    #1;
  endtask

  initial begin
    // Reset
    tick(); tick();
    ARESETn = 1'b1;
    #1;
    chk("rst_total", total_cnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err_uf", err_underflow, 0);
    chk("rst_err_oi", err_overissue, 0);
    chk("rst_block_novalid", req_block, 1);
    req(4'd3, 1'b1, 1'b1, 1'b0);
    chk("rst_block_valid", req_block, 0);

    // 1: single issue and retire on id 3
    req(4'd3, 1'b1, 1'b1, 1'b1);
    tick();
    req(4'd3, 1'b1, 1'b0, 1'b0);
    chk("t1_total_issue", total_cnt, 1);
    chk("t1_idle_busy", idle, 0);
    req(4'd3, 1'b0, 1'b1, 1'b0);
    chk("t1_hazard_id3", req_block, 1);
    rsp(4'd3, 1'b1, 1'b1);
    tick();
    rsp(4'd3, 1'b0, 1'b0);
    chk("t1_total_retire", total_cnt, 0);
    chk("t1_idle_again", idle, 1);
    chk("t1_id3_free", req_block, 0);

    // 2: per-ID cap and destination hazard on id 5
    req(4'd5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    req(4'd5, 1'b0, 1'b1, 1'b0);
    chk("t2_total4", total_cnt, 4);
    chk("t2_full_same_dest", req_block, 1);
    req(4'd5, 1'b1, 1'b1, 1'b0);
    chk("t2_hazard_dest1", req_block, 1);
    rsp(4'd5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    rsp(4'd5, 1'b1, 1'b0);
    chk("t2_total1", total_cnt, 1);
    chk("t2_hazard_one_left", req_block, 1);
    rsp(4'd5, 1'b1, 1'b1);
    tick();
    rsp(4'd5, 1'b1, 1'b0);
    chk("t2_total0", total_cnt, 0);
    chk("t2_dest1_free", req_block, 0);

    // 3: port total cap and same-cycle retire bypass
    for (int i = 0; i < 8; i++) begin
      req(4'(i), 1'b0, 1'b1, 1'b1);
      tick();
    end
    req(4'd9, 1'b0, 1'b1, 1'b0);
    chk("t3_total8", total_cnt, 8);
    chk("t3_total_full_block", req_block, 1);
    rsp(4'd2, 1'b1, 1'b1);
    chk("t3_bypass_unblock", req_block, 0);
    req(4'd9, 1'b0, 1'b1, 1'b1);
    tick();
    req(4'd9, 1'b0, 1'b0, 1'b0);
    rsp(4'd2, 1'b1, 1'b0);
    chk("t3_total_stays8", total_cnt, 8);
    req(4'd2, 1'b1, 1'b1, 1'b0);
    chk("t3_id2_retired", req_block, 1);
    req(4'd9, 1'b1, 1'b1, 1'b0);
    chk("t3_id9_hazard", req_block, 1);
    req(4'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rsp((i == 2) ? 4'd9 : 4'(i), 1'b1, 1'b1);
      tick();
    end
    rsp(4'd0, 1'b0, 1'b0);
    chk("t3_drained", total_cnt, 0);
    chk("t3_idle", idle, 1);
    chk("t3_no_underflow", err_underflow, 0);

    // 4: multi-beat responses, last-beat retire vs every-beat retire
    req(4'd2, 1'b0, 1'b1, 1'b1);
    tick();
    req(4'd2, 1'b1, 1'b1, 1'b0);
    rsp(4'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    rsp(4'd2, 1'b0, 1'b0);
    chk("t4_nonlast_total", total_cnt, 1);
    chk("t4_nonlast_hazard", req_block, 1);
    rsp(4'd2, 1'b1, 1'b1);
    tick();
    rsp(4'd2, 1'b0, 1'b0);
    chk("t4_last_total", total_cnt, 0);
    chk("t4_last_free", req_block, 0);
    req(4'd2, 1'b1, 1'b0, 1'b0);

    b_req_id = 4'd2; b_req_dest = 1'b0; b_req_valid = 1'b1; b_req_fire = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    b_req_valid = 1'b0; b_req_fire = 1'b0;
    #1;
    chk("t4b_total3", b_total_cnt, 3);
    b_rsp_id = 4'd2; b_rsp_last = 1'b0; b_rsp_fire = 1'b1;
    tick();
    chk("t4b_beat1", b_total_cnt, 2);
    tick();
    chk("t4b_beat2", b_total_cnt, 1);
    tick();
    chk("t4b_beat3", b_total_cnt, 0);
    chk("t4b_no_uf", b_err_underflow, 0);
    tick();
    b_rsp_fire = 1'b0;
    #1;
    chk("t4b_uf", b_err_underflow, 1);
    chk("t4b_uf_total", b_total_cnt, 0);

    // 5: same-cycle issue and retire on one ID, underflow, overissue
    req(4'd1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    chk("t5_total2", total_cnt, 2);
    rsp(4'd1, 1'b1, 1'b1);
    chk("t5_same_cycle_unblock", req_block, 0);
    tick();
    req(4'd1, 1'b0, 1'b1, 1'b0);
    rsp(4'd1, 1'b1, 1'b0);
    chk("t5_total_unchanged", total_cnt, 2);
    rsp(4'd1, 1'b1, 1'b1);
    tick();
    rsp(4'd1, 1'b1, 1'b0);
    chk("t5_total1", total_cnt, 1);
    chk("t5_cnt1_nonzero", req_block, 1);
    rsp(4'd1, 1'b1, 1'b1);
    tick();
    rsp(4'd1, 1'b1, 1'b0);
    chk("t5_total0", total_cnt, 0);
    chk("t5_cnt1_zero", req_block, 0);
    rsp(4'd6, 1'b1, 1'b1);
    tick();
    rsp(4'd6, 1'b1, 1'b0);
    chk("t5_uf_flag", err_underflow, 1);
    chk("t5_uf_total", total_cnt, 0);
    chk("t5_oi_clear", err_overissue, 0);
    req(4'd1, 1'b0, 1'b0, 1'b1);
    tick();
    req(4'd1, 1'b0, 1'b0, 1'b0);
    chk("t5_oi_flag", err_overissue, 1);
    chk("t5_oi_total", total_cnt, 0);

    // 6: reset mid-operation
    for (int i = 10; i < 15; i++) begin
      req(4'(i), 1'b1, 1'b1, 1'b1);
      tick();
    end
    req(4'd10, 1'b0, 1'b1, 1'b0);
    chk("t6_total5", total_cnt, 5);
    chk("t6_hazard_before", req_block, 1);
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    #1;
    chk("t6_total0", total_cnt, 0);
    chk("t6_idle", idle, 1);
    chk("t6_uf_clear", err_underflow, 0);
    chk("t6_oi_clear", err_overissue, 0);
    chk("t6_b_uf_clear", b_err_underflow, 0);
    chk("t6_id10_free", req_block, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
